factorial_ctrl: RTL

//   Moore FSM that sequences the factorial datapath (count register, product

---
 rtl/factorial_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/factorial_ctrl.sv
// Moore controller that sequences the factorial datapath (count/product registers)
// through a go/done handshake, with an iteration guard against a stuck comparator.
module factorial_ctrl #(
    parameter int SIZE  = 4,
    parameter int MAX_N = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_go,
    input  logic [SIZE-1:0] i_n,
    input  logic            i_cnt_gt_1,
    input  logic            i_ovf,
    output logic            o_load_cnt,
    output logic            o_sel_cnt,
    output logic            o_load_reg,
    output logic            o_sel_reg,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TEST,
        MULT,
        DONE,
        ERR
    } state_t;

    localparam logic [SIZE-1:0] MAX_N_L = SIZE'(MAX_N);

    state_t          r_state;
    state_t          w_nextState;
    logic [SIZE-1:0] r_iter;
    logic [SIZE-1:0] w_iterInc;

    assign w_iterInc = r_iter + SIZE'(1);

    // State register plus the guard counter, cleared on entry to the loop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_iter  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == INIT) begin
                r_iter <= '0;
            end else if (r_state == MULT) begin
                r_iter <= w_iterInc;
            end
        end
    end

    // Next-state logic; guard trips when this MULT would be the MAX_N-th one.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_go) begin
                    w_nextState = (i_n > MAX_N_L) ? ERR : INIT;
                end
            end
            INIT: w_nextState = TEST;
            TEST: w_nextState = i_cnt_gt_1 ? MULT : DONE;
            MULT: begin
                if (i_ovf || (w_iterInc == MAX_N_L)) begin
                    w_nextState = ERR;
                end else begin
                    w_nextState = TEST;
                end
            end
            DONE: if (!i_go) w_nextState = IDLE;
            ERR:  if (!i_go) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs depend on the registered state only, so reset clears them at once.
    always_comb begin
        o_load_cnt = 1'b0;
        o_sel_cnt  = 1'b0;
        o_load_reg = 1'b0;
        o_sel_reg  = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        case (r_state)
            INIT: begin
                o_load_cnt = 1'b1;
                o_load_reg = 1'b1;
                o_busy     = 1'b1;
            end
            TEST: o_busy = 1'b1;
            MULT: begin
                o_load_cnt = 1'b1;
                o_sel_cnt  = 1'b1;
                o_load_reg = 1'b1;
                o_sel_reg  = 1'b1;
                o_busy     = 1'b1;
            end
            DONE: o_done = 1'b1;
            ERR:  o_err  = 1'b1;
            default: ;
        endcase
    end

endmodule
